bus_rr_lock_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer that shares the single system bus (DRAM + MMIO data port) among NREQ cores.

---
 rtl/bus_rr_lock_arbiter_if.sv | 25 ++
 rtl/bus_rr_lock_arbiter.sv | 141 ++++++++++++++
 tb/tb_bus_rr_lock_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bus_rr_lock_arbiter_if.sv
// rtl/bus_rr_lock_arbiter_if.sv - per-core request and shared-bus handshake bundle for the bus arbiter
// The arbiter connects through the slave modport. The core/bus side connects through the master modport.
interface bus_rr_lock_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0] i_req;
  logic [NREQ-1:0] i_lock;
  logic            i_sys_busy;
  logic            o_start;
  logic [NREQ-1:0] o_grant;
  logic [IDW-1:0]  o_grant_id;
  logic [NREQ-1:0] o_done;
  logic            o_locked;

  modport slave (
    input  i_req, i_lock, i_sys_busy,
    output o_start, o_grant, o_grant_id, o_done, o_locked
  );

  modport master (
    output i_req, i_lock, i_sys_busy,
    input  o_start, o_grant, o_grant_id, o_done, o_locked
  );
endinterface

// File: rtl/bus_rr_lock_arbiter.sv
// rtl/bus_rr_lock_arbiter.sv - round-robin shared-bus sequencer with per-owner lock for AMO sequences
// Each grant runs one bus transaction: issue, wait for busy, wait for idle, then complete.
module bus_rr_lock_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int ACK_TMO  = 255,
  parameter int LOCK_MAX = 15
) (
  input  logic                   CLK,
  input  logic                   RST_X,
  input  logic                   w_init_done,
  bus_rr_lock_arbiter_if.slave   bus,
  output logic                   o_err_tmo
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ACK, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]  gid_q, gid_d;
  logic [IDW-1:0]  last_q, last_d;
  logic            locked_q, locked_d;
  logic [3:0]      lock_cnt_q, lock_cnt_d;
  logic [7:0]      ack_cnt_q, ack_cnt_d;
  logic            err_q, err_d;

  logic            owner_req;
  logic [NREQ-1:0] elig;
  logic            pick_valid;
  logic [IDW-1:0]  pick_id;

  // A lock only narrows eligibility while its owner is still requesting.
  assign owner_req = |(grant_q & bus.i_req);
  assign elig      = (locked_q && owner_req) ? (grant_q & bus.i_req) : bus.i_req;

  // Scan from farthest to nearest so the closest candidate after last_q wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(last_q) + i) % NREQ;
      if (elig[idx[IDW-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gid_d      = gid_q;
    last_d     = last_q;
    locked_d   = locked_q;
    lock_cnt_d = lock_cnt_q;
    ack_cnt_d  = ack_cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (w_init_done) begin
          if (locked_q && !owner_req) begin
            locked_d   = 1'b0;
            lock_cnt_d = '0;
            grant_d    = '0;
          end
          if (pick_valid) begin
            grant_d = NREQ'(1) << pick_id;
            gid_d   = pick_id;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        ack_cnt_d = '0;
        state_d   = S_ACK;
      end
      S_ACK: begin
        if (bus.i_sys_busy) begin
          state_d = S_BUSY;
        end else if (ack_cnt_q == 8'(ACK_TMO - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          ack_cnt_d = ack_cnt_q + 8'd1;
        end
      end
      S_BUSY: begin
        if (!bus.i_sys_busy) state_d = S_DONE;
      end
      S_DONE: begin
        last_d = gid_q;
        if (|(grant_q & bus.i_lock) && (lock_cnt_q < 4'(LOCK_MAX))) begin
          locked_d   = 1'b1;
          lock_cnt_d = lock_cnt_q + 4'd1;
        end else begin
          locked_d   = 1'b0;
          lock_cnt_d = '0;
          grant_d    = '0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      gid_q      <= '0;
      last_q     <= IDW'(NREQ - 1);
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
      ack_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gid_q      <= gid_d;
      last_q     <= last_d;
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_start    = (state_q == S_ISSUE);
  assign bus.o_grant    = grant_q;
  assign bus.o_grant_id = gid_q;
  assign bus.o_done     = (state_q == S_DONE) ? grant_q : '0;
  assign bus.o_locked   = locked_q;
  assign o_err_tmo      = err_q;

  // The shared controller must never be busy while the arbiter could launch a transaction.
  a_no_busy_in_idle: assert property (@(posedge CLK) disable iff (!RST_X)
    !(state_q == S_IDLE && w_init_done && bus.i_sys_busy));

endmodule

// File: tb/tb_bus_rr_lock_arbiter.sv
// tb/tb_bus_rr_lock_arbiter.sv - directed self-checking bench for bus_rr_lock_arbiter
module tb_bus_rr_lock_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic init = 1'b0;
  logic err;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cnt;
  logic lk;

  bus_rr_lock_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

  bus_rr_lock_arbiter #(.NREQ(4), .IDW(2), .ACK_TMO(255), .LOCK_MAX(15)) dut (
    .CLK         (clk),
    .RST_X       (rstn),
    .w_init_done (init),
    .bus         (bus),
    .o_err_tmo   (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction for the expected owner; next_req is applied at the o_done cycle.
  task automatic txn(input string tag, input int nbusy, input logic [3:0] exp_g,
                     input logic [3:0] next_req, output logic lk_o);
    for (int k = 0; k < 10 && bus.o_start !== 1'b1; k++) step();
    chk({tag, "_start"}, bus.o_start, 1);
    chk({tag, "_grant"}, bus.o_grant, exp_g);
    lk_o = bus.o_locked;
    bus.i_sys_busy = 1'b1;
    repeat (nbusy) step();
    chk({tag, "_nodone"}, bus.o_done, 0);
    bus.i_sys_busy = 1'b0;
    step();
    chk({tag, "_done"}, bus.o_done, exp_g);
    bus.i_req = next_req;
  endtask

  initial begin
    bus.i_req      = '0;
    bus.i_lock     = '0;
    bus.i_sys_busy = 1'b0;
    repeat (2) step();

    chk("rst_start", bus.o_start, 0);
    chk("rst_grant", bus.o_grant, 0);
    chk("rst_id", bus.o_grant_id, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_locked", bus.o_locked, 0);
    chk("rst_err", err, 0);

    // Single uncontended transaction
    rstn = 1'b1;
    init = 1'b1;
    bus.i_req = 4'b0001;
    step();
    chk("t1_start_lat", bus.o_start, 1);
    chk("t1_grant", bus.o_grant, 4'b0001);
    chk("t1_id", bus.o_grant_id, 0);
    bus.i_sys_busy = 1'b1;
    step();
    chk("t1_start_pulse", bus.o_start, 0);
    step();
    step();
    chk("t1_nodone", bus.o_done, 0);
    bus.i_sys_busy = 1'b0;
    step();
    chk("t1_done", bus.o_done, 4'b0001);
    bus.i_req = 4'b0000;
    step();
    chk("t1_grant_clr", bus.o_grant, 0);
    chk("t1_done_clr", bus.o_done, 0);

    // All four request from reset: order 0,1,2,3,0
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    bus.i_req = 4'b1111;
    txn("t2_g0", 2, 4'b0001, 4'b1111, lk);
    txn("t2_g1", 3, 4'b0010, 4'b1111, lk);
    txn("t2_g2", 2, 4'b0100, 4'b1111, lk);
    txn("t2_g3", 4, 4'b1000, 4'b1111, lk);
    txn("t2_g0b", 2, 4'b0001, 4'b1111, lk);

    // Core1 locks: 16 consecutive transactions then forced release to core2
    bus.i_lock = 4'b0010;
    for (int k = 0; k < 16; k++) begin
      txn($sformatf("t3_l%0d", k), 2, 4'b0010, 4'b1111, lk);
      chk($sformatf("t3_lk%0d", k), lk, (k == 0) ? 1'b0 : 1'b1);
    end
    txn("t3_rel", 2, 4'b0100, 4'b0100, lk);
    chk("t3_rel_lk", lk, 0);
    bus.i_lock = 4'b0000;

    // Core2 alone, bus never answers: ACK timeout
    for (int k = 0; k < 10 && bus.o_start !== 1'b1; k++) step();
    chk("t4_start", bus.o_start, 1);
    chk("t4_grant", bus.o_grant, 4'b0100);
    chk("t4_err_pre", err, 0);
    cnt = 0;
    for (int k = 0; k < 300 && bus.o_done === 4'b0000; k++) begin
      step();
      cnt++;
    end
    chk("t4_tmo_cycles", cnt, 256);
    chk("t4_done", bus.o_done, 4'b0100);
    chk("t4_err", err, 1);
    bus.i_req = 4'b0000;
    repeat (3) step();
    chk("t4_err_sticky", err, 1);
    chk("t4_grant_clr", bus.o_grant, 0);
    chk("t4_id_keep", bus.o_grant_id, 2);

    // Reset during S_BUSY
    bus.i_req = 4'b0100;
    for (int k = 0; k < 10 && bus.o_start !== 1'b1; k++) step();
    chk("t5_start", bus.o_start, 1);
    bus.i_sys_busy = 1'b1;
    step();
    step();
    rstn = 1'b0;
    bus.i_sys_busy = 1'b0;
    step();
    chk("t5_grant", bus.o_grant, 0);
    chk("t5_done", bus.o_done, 0);
    chk("t5_id", bus.o_grant_id, 0);
    chk("t5_err", err, 0);
    chk("t5_start0", bus.o_start, 0);
    rstn = 1'b1;
    bus.i_req = 4'b1111;
    txn("t5_first", 2, 4'b0001, 4'b0000, lk);

    // Locked owner drops its request while core3 waits
    bus.i_lock = 4'b0010;
    bus.i_req = 4'b0010;
    txn("t6_own", 2, 4'b0010, 4'b1000, lk);
    step();
    chk("t6_locked", bus.o_locked, 1);
    chk("t6_hold", bus.o_grant, 4'b0010);
    step();
    chk("t6_unlock", bus.o_locked, 0);
    chk("t6_grant", bus.o_grant, 4'b1000);
    chk("t6_id", bus.o_grant_id, 3);
    chk("t6_start", bus.o_start, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
